bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 14, binary input width in bits.
REQ-002 Parameter DIGITS, default 4, number of BCD digits produced; 10^DIGITS-1 SHALL be representable in BIN_W bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-005 start  input  1  conversion request, sampled each clk edge.
REQ-006 bin_in  input  BIN_W  unsigned binary value, captured on accepted start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle pulse, result valid and just updated.
REQ-009 bcd_out  output  4*DIGITS  digit codes, digit 0 in bits [3:0]; each nibble feeds one 7-segment digit decoder directly.
REQ-010 overflow  output  1  last captured bin_in exceeded 10^DIGITS-1.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 IDLE: busy=0, done=0; start=1 -> capture bin_in into shift register, clear BCD scratch, load bit counter with BIN_W, go to SHIFT.
REQ-013 SHIFT: busy=1; each cycle add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one; decrement counter; after the BIN_W-th shift go to DONE.
REQ-014 DONE: busy=0, done=1 for exactly one cycle; bcd_out and overflow SHALL update on the same edge that enters DONE.
REQ-015 Latency: start accepted at edge N -> done high in the cycle after edge N+BIN_W (BIN_W+1 cycles; 15 for BIN_W=14).
REQ-016 start SHALL be accepted in IDLE and in DONE (back-to-back); in DONE with start=1 go directly to SHIFT, else to IDLE.
REQ-017 start during SHIFT SHALL be ignored; bin_in is not re-sampled.
REQ-018 If the captured value > 10^DIGITS-1: overflow=1 and every nibble of bcd_out = 4'h9; otherwise overflow=0.
REQ-019 bcd_out and overflow SHALL hold their last value outside DONE-entry edges.
REQ-020 Nibble values other than 0-9 SHALL be emitted only as 4'hF (blank) per REQ-022/REQ-025.

Reset
REQ-021 reset=1 SHALL force IDLE, busy=0, done=0, overflow=0, counter=0, scratch=0, aborting any conversion in progress.
REQ-022 reset SHALL set every nibble of bcd_out to 4'hF (display blank); no done pulse follows reset.
REQ-023 start asserted together with reset SHALL be ignored; it is accepted from the first cycle after reset deasserts.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-025 Defined: on DONE entry, each zero nibble above the most significant nonzero digit SHALL be 4'hF; digit 0 SHALL never be blanked; overflow results are not blanked.
REQ-026 Not defined: all nibbles carry the plain BCD digit including leading zeros; no blanking logic SHALL be synthesized.

Verification (BIN_W=14, DIGITS=4)
REQ-027 Reset then bin_in=1234, start 1 cycle -> busy 14 cycles, done in 15th cycle, bcd_out=16'h1234, overflow=0.
REQ-028 bin_in=0 -> bcd_out=16'h0000 without macro; 16'hFFF0 with LEADING_ZERO_BLANK_EN; bin_in=42 with macro -> 16'hFF42.
REQ-029 bin_in=9999 -> 16'h9999, overflow=0; then bin_in=10000 -> 16'h9999, overflow=1; bin_in=16383 -> same.
REQ-030 Start 1234; pulse start with bin_in=5678 during SHIFT -> ignored, result 16'h1234; hold start high in DONE with bin_in=5678 -> next done 15 cycles later, bcd_out=16'h5678.
REQ-031 Start 4321; assert reset 5 cycles later -> busy=0, done never pulses, bcd_out=16'hFFFF; new start 7 -> 16'h0007 (16'hFFF7 with macro).

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// A start in IDLE or DONE captures bin_in. BIN_W shift cycles follow, then one
// DONE cycle. bcd_out and overflow are registered and change only on the edge
// that enters DONE.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (4'hF). Digit 0 and overflow results are never blanked.
//
// Handshake: start is a request with no back-pressure. It is accepted on any
// rising edge where reset=0, start=1 and the FSM is in IDLE or DONE. The
// busy=0 output shows that the converter can accept a start. done is a
// one-cycle valid pulse for bcd_out/overflow. start during SHIFT is dropped.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [1:0]            state_dbg_o
);

    localparam int              BCD_W   = 4 * DIGITS;
    localparam int              CNT_W   = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     scratch_q, scratch_d;
    logic [BIN_W-1:0]     shreg_q, shreg_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 last_shift;
    logic [BCD_W-1:0]     adj;
    logic [BCD_W+BIN_W-1:0] cat_nx;
    logic [BCD_W-1:0]     scratch_nx;
    logic [BIN_W-1:0]     shreg_nx;
    logic [BCD_W-1:0]     digits_fmt;

    // A start is taken only when no conversion is running.
    assign accept     = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_shift = (cnt_q == CNT_W'(1));

    // Add-3 correction: any scratch digit >= 5 is fixed up before it doubles.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift the {scratch, shift register} pair left by one bit.
    assign cat_nx     = {adj, shreg_q} << 1;
    assign scratch_nx = cat_nx[BCD_W+BIN_W-1 -: BCD_W];
    assign shreg_nx   = cat_nx[BIN_W-1:0];

`ifdef LEADING_ZERO_BLANK_EN
    // Blank zero digits above the most significant nonzero digit.
    always_comb begin
        logic leading;
        digits_fmt = scratch_nx;
        leading    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && scratch_nx[4*i +: 4] == 4'd0) begin
                digits_fmt[4*i +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign digits_fmt = scratch_nx;
`endif

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            S_SHIFT: if (last_shift) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture, shift, or publish the result.
    always_comb begin
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        shreg_d    = shreg_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        if (accept) begin
            shreg_d    = bin_in;
            scratch_d  = '0;
            cnt_d      = CNT_W'(BIN_W);
            ovf_pend_d = (bin_in > MAX_VAL);
        end else if (state_q == S_SHIFT) begin
            shreg_d   = shreg_nx;
            scratch_d = scratch_nx;
            cnt_d     = cnt_q - CNT_W'(1);
            if (last_shift) begin
                ovf_d = ovf_pend_q;
                bcd_d = ovf_pend_q ? {DIGITS{4'h9}} : digits_fmt;
            end
        end
    end

    // State register. Reset clears the state and aborts any conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers. Reset blanks the display and clears the scratch.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            scratch_q  <= '0;
            shreg_q    <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= {DIGITS{4'hF}};
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            shreg_q    <= shreg_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    // Outputs decoded from the state, plus the registered result.
    always_comb begin
        busy        = (state_q == S_SHIFT);
        done        = (state_q == S_DONE);
        bcd_out     = bcd_q;
        overflow    = ovf_q;
        state_dbg_o = state_q;
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq (BIN_W=14, DIGITS=4).
// The driver pushes the expected result and done cycle for each accepted start.
// The negedge monitor checks every done pulse against the queue. It also checks
// that outputs hold between done pulses and that busy lasts exactly BIN_W cycles.
// The same LEADING_ZERO_BLANK_EN build option selects blanking in the model.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int W      = BCD_W + 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_out;
  logic             overflow;
  logic [1:0]       state_dbg;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .overflow    (overflow),
    .state_dbg_o (state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decimal digits by division, then optional blanking.
  function automatic logic [W-1:0] model(input int v);
    logic [BCD_W-1:0] b;
    int p;
    int max_val;
    max_val = 1;
    for (int i = 0; i < DIGITS; i++) max_val = max_val * 10;
    max_val = max_val - 1;
    if (v > max_val) return {1'b1, {DIGITS{4'h9}}};
    b = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) b[4*i +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return {1'b0, b};
  endfunction

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("ready_timeout", 64'(busy), 64'd0);
  endtask

  task automatic convert(input int v);
    wait_ready();
    start  = 1'b1;
    bin_in = BIN_W'(v);
    exp_q.push_back(model(v));
    exp_cyc_q.push_back(cyc + BIN_W + 1);
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset(input int cycles, input logic with_start);
    reset = 1'b1;
    start = with_start;
    bin_in = BIN_W'(99);
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (cycles) tick();
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_blank_state(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_bcd"}, 64'(bcd_out), 64'({DIGITS{4'hF}}));
    check({name, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  // monitor / scoreboard
  logic [W-1:0] last_exp;
  int           busy_run;
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           ec;
    if (reset) begin
      last_exp = {1'b0, {DIGITS{4'hF}}};
      busy_run = 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result_bcd", 64'(bcd_out), 64'(e[BCD_W-1:0]));
        check("result_ovf", 64'(overflow), 64'(e[BCD_W]));
        check("done_latency", 64'(cyc), 64'(ec));
        check("busy_length", 64'(busy_run), 64'(BIN_W));
        last_exp = e;
      end
      check("busy_in_done", 64'(busy), 64'd0);
      busy_run = 0;
    end else begin
      check("hold", 64'({overflow, bcd_out}), 64'(last_exp));
      if (busy) busy_run++;
      else busy_run = 0;
    end
  end

  // stimulus
  initial begin
    int n;
    reset = 1'b1; start = 1'b0; bin_in = '0;
    tick(); tick();
    reset = 1'b0;
    check_blank_state("reset");

    // basic conversion and edge values
    convert(1234);
    convert(0);
    convert(42);
    convert(9999);
    convert(10000);
    convert(16383);

    // start pulsed during SHIFT is ignored
    convert(1234);
    tick(); tick();
    start = 1'b1; bin_in = BIN_W'(5678);
    tick();
    start = 1'b0;
    // back-to-back: the second start lands in the DONE cycle
    convert(5678);

    // abort with reset 5 cycles into a conversion
    wait_ready();
    convert(4321);
    repeat (4) tick();
    do_reset(1, 1'b0);
    check_blank_state("abort");
    repeat (20) tick();
    convert(7);

    // start held together with reset is ignored
    wait_ready();
    do_reset(2, 1'b1);
    check_blank_state("rst_start");
    repeat (20) tick();

    // randomized conversions with random gaps
    for (int i = 0; i < 40; i++) begin
      int v;
      case ($urandom_range(0, 3))
        0: v = $urandom_range(9990, 10010);
        1: v = $urandom_range(0, 120);
        default: v = $urandom_range(0, 16383);
      endcase
      convert(v);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 20)) tick();
    end

    // drain
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
